tone_bank: RTL and testbench

//  Multi-channel square-wave tone generator with timed notes; the parametrised successor of the single-channel tone driver.
//  NUM_CH independent channels share one microsecond-scale tick prescaler and one millisecond tick.
//  A valid/ready config port loads a half-period and a duration per channel. Each channel stops itself and pulses note_done.
//  Per-channel pins drive RGB/buzzer outputs; a sigma-delta mix drives a single speaker pin.

---
 rtl/tone_bank_pkg.sv | 19 +
 rtl/tone_bank_if.sv | 28 ++
 rtl/tone_bank_channel.sv | 78 +++++++
 rtl/tone_bank.sv | 107 ++++++++++
 tb/tb_tone_bank.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_bank_pkg.sv
// Shared types and width helpers for the multi-channel tone generator.
// No logic; imported by the interface, channel and top.
package tone_bank_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY_TIMED = 2'd1,
    PLAY_CONT  = 2'd2
  } tone_state_t;

  function automatic int tick_div(input int clk_f);
    return clk_f / 2;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_bank_if.sv
// Config request port: one channel write per valid&&ready transfer.
// The slave side holds ready high after reset, so there is never backpressure.
interface tone_bank_if #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 32,
  parameter int DUR_W    = 16
);
  import tone_bank_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_chan;
  logic [PERIOD_W-1:0] cfg_period;
  logic [DUR_W-1:0]    cfg_dur;

  modport master (
    output cfg_valid, cfg_chan, cfg_period, cfg_dur,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_period, cfg_dur,
    output cfg_ready
  );

endinterface

// File: rtl/tone_bank_channel.sv
// One tone channel: FSM, half-period counter, remaining-ms counter and pin.
// Load takes effect on the next edge and overrides any tick or expiry on that edge.
module tone_bank_channel
  import tone_bank_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int DUR_W    = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                base_tick,
  input  logic                ms_tick,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_period,
  input  logic [DUR_W-1:0]    load_dur,
  output logic                active,
  output logic                note_done,
  output logic                pin
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_TIMED = PLAY_TIMED;
  localparam logic [1:0] S_CONT  = PLAY_CONT;

  logic [1:0]          state;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic [DUR_W-1:0]    rem;
  logic                playing;

  assign playing = (state == S_TIMED) || (state == S_CONT);
  assign active  = playing;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      period    <= '0;
      cnt       <= '0;
      rem       <= '0;
      pin       <= 1'b0;
      note_done <= 1'b0;
    end else begin
      note_done <= 1'b0;
      if (load) begin
        cnt <= '0;
        pin <= 1'b0;
        if (load_period != '0) begin
          period <= load_period;
          rem    <= load_dur;
          state  <= (load_dur != '0) ? S_TIMED : S_CONT;
        end else begin
          state <= S_IDLE;
        end
      end else if (playing) begin
        if (base_tick) begin
          if (cnt == period - PERIOD_W'(1)) begin
            cnt <= '0;
            pin <= ~pin;
          end else begin
            cnt <= cnt + PERIOD_W'(1);
          end
        end
        // ms_tick always lands on a base_tick; expiry must win over the toggle.
        if ((state == S_TIMED) && ms_tick) begin
          if (rem == DUR_W'(1)) begin
            state     <= S_IDLE;
            pin       <= 1'b0;
            cnt       <= '0;
            note_done <= 1'b1;
          end else begin
            rem <= rem - DUR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/tone_bank.sv
// NUM_CH square-wave tone channels sharing a 0.5us prescaler and ms tick, plus a sigma-delta mix pin.
// Config writes take effect one cycle after acceptance; cfg_ready is high from the first cycle out of reset.
module tone_bank
  import tone_bank_pkg::*;
#(
  parameter int CLK_F        = 50,
  parameter int NUM_CH       = 4,
  parameter int PERIOD_W     = 32,
  parameter int DUR_W        = 16,
  parameter int TICKS_PER_MS = 2000
) (
  input  logic              CLK,
  input  logic              RST_N,
  tone_bank_if.slave        cfg,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] note_done,
  output logic [NUM_CH-1:0] BUZZ_PINS,
  output logic              BUZZ_MIX
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int DIV   = tick_div(CLK_F);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MS_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int ACC_W = $clog2(2 * NUM_CH);
  localparam int SUM_W = ACC_W + 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             base_tick;
  logic             ms_tick;
  logic             rdy_q;
  logic             accept;

  assign base_tick = (pre_cnt == PRE_W'(DIV - 1));
  assign ms_tick   = base_tick && (ms_cnt == MS_W'(TICKS_PER_MS - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      pre_cnt <= base_tick ? '0 : pre_cnt + PRE_W'(1);
      if (base_tick) begin
        ms_cnt <= ms_tick ? '0 : ms_cnt + MS_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign cfg.cfg_ready = rdy_q;
  assign accept        = cfg.cfg_valid && rdy_q;

  // Out-of-range channel numbers match no instance, so they are accepted and dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_bank_channel #(
      .PERIOD_W (PERIOD_W),
      .DUR_W    (DUR_W)
    ) u_ch (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .base_tick   (base_tick),
      .ms_tick     (ms_tick),
      .load        (accept && (cfg.cfg_chan == CH_W'(i))),
      .load_period (cfg.cfg_period),
      .load_dur    (cfg.cfg_dur),
      .active      (ch_active[i]),
      .note_done   (note_done[i]),
      .pin         (BUZZ_PINS[i])
    );
  end

  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] mix_sum;
  logic [ACC_W-1:0] acc;

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pop = pop + SUM_W'(BUZZ_PINS[k]);
    end
  end

  assign mix_sum = SUM_W'(acc) + pop;

  // First-order sigma-delta: acc stays below NUM_CH, so one-hot density equals pop/NUM_CH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc      <= '0;
      BUZZ_MIX <= 1'b0;
    end else if (mix_sum >= SUM_W'(NUM_CH)) begin
      acc      <= ACC_W'(mix_sum - SUM_W'(NUM_CH));
      BUZZ_MIX <= 1'b1;
    end else begin
      acc      <= ACC_W'(mix_sum);
      BUZZ_MIX <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank with a closed-form timing model checked every cycle.
`timescale 1ns/1ps
module tb_tone_bank;

  localparam int NCH  = 4;
  localparam int PW   = 32;
  localparam int DW   = 16;
  localparam int CLKF = 50;
  localparam int TPM  = 4;
  localparam int BT   = CLKF / 2;
  localparam int MSP  = BT * TPM;

  logic           CLK;
  logic           RST_N;
  logic [NCH-1:0] ch_active;
  logic [NCH-1:0] note_done;
  logic [NCH-1:0] BUZZ_PINS;
  logic           BUZZ_MIX;

  tone_bank_if #(.NUM_CH(NCH), .PERIOD_W(PW), .DUR_W(DW)) cfg ();

  tone_bank #(
    .CLK_F(CLKF), .NUM_CH(NCH), .PERIOD_W(PW), .DUR_W(DW), .TICKS_PER_MS(TPM)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .cfg(cfg),
    .ch_active(ch_active), .note_done(note_done),
    .BUZZ_PINS(BUZZ_PINS), .BUZZ_MIX(BUZZ_MIX)
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  bit chk_en = 0;

  // Model: per channel the accepted note (edge index, period, duration).
  bit     m_on[NCH];
  int     m_e[NCH];
  longint m_p[NCH];
  int     m_d[NCH];
  int     acc_m;
  int     s_prev;

  initial begin
    CLK = 0;
    forever #10 CLK = ~CLK;
  end

  // Edge index since reset release; edge k carries a base tick when k%BT==BT-1.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ms_end(input int ch);
    return ((m_e[ch] + 1) / MSP + m_d[ch]) * MSP - 1;
  endfunction

  function automatic bit m_active(input int ch, input int t);
    if (!m_on[ch]) return 0;
    if (m_d[ch] == 0) return 1;
    return t < ms_end(ch);
  endfunction

  function automatic bit m_pin(input int ch, input int t);
    longint n;
    if (!m_active(ch, t)) return 0;
    n = longint'((t + 1) / BT - (m_e[ch] + 1) / BT);
    return ((n / m_p[ch]) % 2) == 1;
  endfunction

  function automatic bit m_done(input int ch, input int t);
    return m_on[ch] && (m_d[ch] != 0) && (t == ms_end(ch));
  endfunction

  always @(negedge CLK) begin : cmp
    logic [NCH-1:0] ea, ed, ep;
    logic           em, er;
    int             t, sum;
    if (chk_en) begin
      ea = '0; ed = '0; ep = '0; em = 0; er = 0;
      if (!RST_N || cyc == 0) begin
        acc_m  = 0;
        s_prev = 0;
      end else begin
        t   = cyc - 1;
        er  = 1;
        sum = acc_m + s_prev;
        if (sum >= NCH) begin em = 1; acc_m = sum - NCH; end
        else            begin em = 0; acc_m = sum;       end
        for (int ch = 0; ch < NCH; ch++) begin
          ea[ch] = m_active(ch, t);
          ed[ch] = m_done(ch, t);
          ep[ch] = m_pin(ch, t);
        end
        s_prev = $countones(ep);
      end
      check("cfg_ready", cfg.cfg_ready, er);
      check("ch_active", ch_active, ea);
      check("note_done", note_done, ed);
      check("buzz_pins", BUZZ_PINS, ep);
      check("buzz_mix",  BUZZ_MIX,  em);
    end
  end

  task automatic wr(input int ch, input longint p, input int d);
    int e;
    @(negedge CLK); #1;
    cfg.cfg_valid  = 1;
    cfg.cfg_chan   = 2'(ch);
    cfg.cfg_period = 32'(p);
    cfg.cfg_dur    = 16'(d);
    e = cyc;
    @(posedge CLK); #1;
    cfg.cfg_valid = 0;
    if (p != 0) begin
      m_on[ch] = 1; m_e[ch] = e; m_p[ch] = p; m_d[ch] = d;
    end else begin
      m_on[ch] = 0;
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (cyc == target) return;
    end
    total++; bad++;
    $display("FAIL wait_cyc: got %0d want %0d", cyc, target);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (cyc % BT == ph) return;
    end
    total++; bad++;
    $display("FAIL wait_phase: got %0d want %0d", cyc % BT, ph);
  endtask

  initial begin : stim
    int cnt, n_tog, e3, x, done_cyc, full_cnt, full_bad, zero_bad, mix_ones;
    int tog[4];
    logic prev;
    logic [NCH-1:0] prev_pins;

    for (int c = 0; c < NCH; c++) m_on[c] = 0;
    cfg.cfg_valid = 0; cfg.cfg_chan = '0; cfg.cfg_period = '0; cfg.cfg_dur = '0;

    // 1. reset and idle
    RST_N = 1;
    #2 RST_N = 0;
    #1 chk_en = 1;
    check("rst_ready", cfg.cfg_ready, 0);
    check("rst_pins",  BUZZ_PINS, 0);
    check("rst_mix",   BUZZ_MIX, 0);
    repeat (3) @(negedge CLK);
    #3 RST_N = 1;
    #1 check("ready_before_edge", cfg.cfg_ready, 0);
    @(negedge CLK);
    check("ready_after_edge", cfg.cfg_ready, 1);
    cnt = 0;
    repeat (10000) begin
      @(negedge CLK);
      if (BUZZ_PINS != 0) cnt++;
    end
    check("idle_pins_high_cycles", cnt, 0);

    // 2. ch0 continuous, half-period 4 base ticks
    wr(0, 4, 0);
    n_tog = 0; cnt = 0; prev = BUZZ_PINS[0];
    repeat (450) begin
      @(negedge CLK);
      if (note_done[0]) cnt++;
      if (BUZZ_PINS[0] != prev && n_tog < 4) begin tog[n_tog] = cyc; n_tog++; end
      prev = BUZZ_PINS[0];
    end
    check("ch0_toggles", n_tog >= 3, 1);
    check("ch0_gap1", tog[1] - tog[0], 100);
    check("ch0_gap2", tog[2] - tog[1], 100);
    check("ch0_no_done", cnt, 0);
    check("ch0_active", ch_active[0], 1);

    // 3. ch1 timed, period 2, 3 ms
    wr(1, 2, 3);
    e3 = m_e[1];
    n_tog = 0; cnt = 0; done_cyc = 0; prev = BUZZ_PINS[1];
    repeat (400) begin
      @(negedge CLK);
      if (note_done[1]) begin cnt++; done_cyc = cyc - 1; end
      if (BUZZ_PINS[1] != prev && n_tog < 4) begin tog[n_tog] = cyc; n_tog++; end
      prev = BUZZ_PINS[1];
    end
    check("ch1_gap", tog[1] - tog[0], 50);
    check("ch1_done_pulses", cnt, 1);
    check("ch1_len_ok", (done_cyc - e3 >= 201) && (done_cyc - e3 <= 300), 1);
    check("ch1_idle", ch_active[1], 0);
    check("ch1_pin_low", BUZZ_PINS[1], 0);

    // 4a. retrigger exactly on the expiry edge
    wr(1, 2, 2);
    x = ms_end(1);
    wait_cyc(x - 1);
    wr(1, 2, 5);
    @(negedge CLK);
    check("retrig_no_done", note_done[1], 0);
    check("retrig_pin0", BUZZ_PINS[1], 0);
    check("retrig_active", ch_active[1], 1);
    cnt = 0;
    repeat (100) begin
      @(negedge CLK);
      if (note_done[1]) cnt++;
    end
    check("retrig_no_done_later", cnt, 0);

    // 4b. stop mid-note
    wr(2, 3, 0);
    repeat (150) @(negedge CLK);
    wr(2, 0, 0);
    @(negedge CLK);
    check("stop_active", ch_active[2], 0);
    check("stop_pin", BUZZ_PINS[2], 0);
    check("stop_no_done", note_done[2], 0);

    // 5. four synchronized channels, period 1
    wait_phase(1);
    for (int c = 0; c < NCH; c++) wr(c, 1, 0);
    full_cnt = 0; full_bad = 0; zero_bad = 0; prev_pins = BUZZ_PINS;
    repeat (200) begin
      @(negedge CLK);
      if (BUZZ_PINS == 4'hF && prev_pins == 4'hF) begin
        full_cnt++;
        if (BUZZ_MIX != 1) full_bad++;
      end
      if (BUZZ_PINS == 4'h0 && prev_pins == 4'h0 && BUZZ_MIX != 0) zero_bad++;
      prev_pins = BUZZ_PINS;
    end
    check("mix_full_seen", full_cnt >= 80, 1);
    check("mix_full_bad", full_bad, 0);
    check("mix_zero_bad", zero_bad, 0);

    wr(1, 0, 0); wr(2, 0, 0); wr(3, 0, 0);
    wr(0, 16, 0);
    cnt = 0;
    while (BUZZ_PINS[0] == 0 && cnt < 1000) begin @(negedge CLK); cnt++; end
    check("ch0_rise_seen", BUZZ_PINS[0], 1);
    mix_ones = 0;
    repeat (400) begin
      @(negedge CLK);
      if (BUZZ_MIX) mix_ones++;
    end
    check("mix_quarter_density", mix_ones, 100);

    // 6. async reset mid-note, between edges
    wr(2, 3, 4);
    repeat (130) @(negedge CLK);
    #3 RST_N = 0;
    for (int c = 0; c < NCH; c++) m_on[c] = 0;
    #1;
    check("arst_pins", BUZZ_PINS, 0);
    check("arst_active", ch_active, 0);
    check("arst_done", note_done, 0);
    check("arst_mix", BUZZ_MIX, 0);
    check("arst_ready", cfg.cfg_ready, 0);
    repeat (3) @(negedge CLK);
    #3 RST_N = 1;
    cnt = 0;
    repeat (300) begin
      @(negedge CLK);
      if (BUZZ_PINS != 0 || ch_active != 0) cnt++;
    end
    check("post_rst_silent", cnt, 0);
    wr(3, 1, 0);
    repeat (30) @(negedge CLK);
    check("post_rst_replay", ch_active[3], 1);
    repeat (60) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
